recepcao_medida_dht11: RTL and testbench

Measurement front-end for the TUSCA controller. On a request pulse from the control unit it raises the request line to the external DHT11/Arduino bridge, receives a 6-byte 8N1 serial frame, validates header and checksum, and updates the registered temperature and humidity words consumed by the temperature-level logic and the debug mux. It enforces a reception timeout so a silent bridge cannot stall the controller.

---
 rtl/tusca_pkg.sv | 20 ++
 rtl/rx_serial_8N1.sv | 75 +++++++
 rtl/recepcao_medida_dht11.sv | 116 +++++++++++
 tb/tb_recepcao_medida_dht11.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tusca_pkg.sv
// Shared definitions for the TUSCA measurement front-end: FSM state codes,
// the default frame header and the frame geometry.
package tusca_pkg;

  typedef enum logic [2:0] {
    INICIAL           = 3'd0,
    AGUARDA_CABECALHO = 3'd1,
    RECEBE_DADOS      = 3'd2,
    VERIFICA          = 3'd3,
    PRONTO            = 3'd4,
    ERRO_DADOS        = 3'd5,
    ERRO_TIMEOUT      = 3'd6
  } estado_t;

  localparam logic [7:0] HEADER_PADRAO = 8'hAA;
  localparam int         FRAME_LEN     = 6;
  // Bytes following the header: four payload bytes plus the checksum.
  localparam int         DATA_BYTES    = FRAME_LEN - 1;

endpackage

// File: rtl/rx_serial_8N1.sv
// 8N1 serial receiver: 2-FF synchroniser, start-bit qualification at half a
// bit, then data and stop sampled at bit centres.
module rx_serial_8N1 #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_serial,
  output logic [7:0] dado,
  output logic       byte_valido,
  output logic       erro_framing
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FIM_BIT   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MEIO_BIT  = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_estado_t;

  rx_estado_t      rx_estado, rx_prox;
  logic            rx_s1, rx_s2, rx_s3;
  logic [CW-1:0]   baud_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rx_estado <= RX_IDLE;
    else        rx_estado <= rx_prox;
  end

  // A start edge that has vanished by mid-bit is treated as a glitch.
  always_comb begin
    rx_prox = rx_estado;
    case (rx_estado)
      RX_IDLE:  if (rx_s3 && !rx_s2) rx_prox = RX_START;
      RX_START: if (baud_cnt == MEIO_BIT) rx_prox = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (baud_cnt == FIM_BIT && bit_cnt == 3'd7) rx_prox = RX_STOP;
      RX_STOP:  if (baud_cnt == FIM_BIT) rx_prox = RX_IDLE;
      default:  rx_prox = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_s1        <= 1'b1;
      rx_s2        <= 1'b1;
      rx_s3        <= 1'b1;
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      byte_valido  <= 1'b0;
      erro_framing <= 1'b0;
    end else begin
      rx_s1        <= rx_serial;
      rx_s2        <= rx_s1;
      rx_s3        <= rx_s2;
      byte_valido  <= 1'b0;
      erro_framing <= 1'b0;
      if (rx_estado != rx_prox || baud_cnt == FIM_BIT) baud_cnt <= '0;
      else                                             baud_cnt <= baud_cnt + 1'b1;
      if (rx_estado == RX_START) bit_cnt <= '0;
      if (rx_estado == RX_DATA && baud_cnt == FIM_BIT) begin
        shift   <= {rx_s2, shift[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (rx_estado == RX_STOP && baud_cnt == FIM_BIT) begin
        byte_valido  <= rx_s2;
        erro_framing <= !rx_s2;
      end
    end
  end

  assign dado = shift;

endmodule

// File: rtl/recepcao_medida_dht11.sv
// Measurement front-end: requests a reading from the DHT11 bridge, receives
// and validates the 6-byte frame, and holds the last good temperature/humidity.
module recepcao_medida_dht11
  import tusca_pkg::*;
#(
  parameter int          CLKS_PER_BIT   = 434,
  parameter int          TIMEOUT_CICLOS = 100_000_000,
  parameter logic [7:0]  HEADER         = HEADER_PADRAO
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        medir,
  input  logic        rx_serial,
  output logic        medir_dht11_out,
  output logic        pronto,
  output logic        erro_timeout,
  output logic        erro_dados,
  output logic [15:0] temperatura,
  output logic [15:0] umidade,
  output logic [2:0]  db_estado
);

  localparam int TW = $clog2(TIMEOUT_CICLOS);

  estado_t         estado, prox;
  logic [7:0]      dado;
  logic            byte_valido, erro_framing;
  logic [TW-1:0]   cont_timeout;
  logic            timeout_fim;
  logic [2:0]      byte_cnt;
  logic [7:0]      buffer [DATA_BYTES];
  logic [7:0]      soma;

  rx_serial_8N1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock        (clock),
    .reset        (reset),
    .rx_serial    (rx_serial),
    .dado         (dado),
    .byte_valido  (byte_valido),
    .erro_framing (erro_framing)
  );

  assign timeout_fim = (cont_timeout == TW'(TIMEOUT_CICLOS - 1));
  assign soma        = buffer[0] + buffer[1] + buffer[2] + buffer[3];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= INICIAL;
    else        estado <= prox;
  end

  // Timeout wins over a byte completing in the same cycle.
  always_comb begin
    prox = estado;
    case (estado)
      INICIAL:
        if (medir) prox = AGUARDA_CABECALHO;
      AGUARDA_CABECALHO:
        if (timeout_fim)                         prox = ERRO_TIMEOUT;
        else if (byte_valido && dado == HEADER)  prox = RECEBE_DADOS;
      RECEBE_DADOS:
        if (timeout_fim)                         prox = ERRO_TIMEOUT;
        else if (erro_framing)                   prox = ERRO_DADOS;
        else if (byte_valido && byte_cnt == 3'(DATA_BYTES - 1))
                                                 prox = VERIFICA;
      VERIFICA:
        prox = (soma == buffer[DATA_BYTES-1]) ? PRONTO : ERRO_DADOS;
      PRONTO, ERRO_DADOS, ERRO_TIMEOUT:
        prox = INICIAL;
      default:
        prox = INICIAL;
    endcase
  end

  always_comb begin
    medir_dht11_out = 1'b0;
    pronto          = 1'b0;
    erro_dados      = 1'b0;
    erro_timeout    = 1'b0;
    case (estado)
      AGUARDA_CABECALHO, RECEBE_DADOS, VERIFICA: medir_dht11_out = 1'b1;
      PRONTO:       pronto       = 1'b1;
      ERRO_DADOS:   erro_dados   = 1'b1;
      ERRO_TIMEOUT: erro_timeout = 1'b1;
      default: ;
    endcase
  end

  assign db_estado = estado;

  // Results load on entry to PRONTO so they appear together with the pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cont_timeout <= '0;
      byte_cnt     <= '0;
      temperatura  <= '0;
      umidade      <= '0;
      for (int i = 0; i < DATA_BYTES; i++) buffer[i] <= '0;
    end else begin
      if (estado == INICIAL)
        cont_timeout <= '0;
      else if (estado == AGUARDA_CABECALHO || estado == RECEBE_DADOS)
        cont_timeout <= cont_timeout + 1'b1;
      if (estado != RECEBE_DADOS) begin
        byte_cnt <= '0;
      end else if (byte_valido && !timeout_fim) begin
        buffer[byte_cnt] <= dado;
        byte_cnt         <= byte_cnt + 1'b1;
      end
      if (prox == PRONTO) begin
        temperatura <= {buffer[0], buffer[1]};
        umidade     <= {buffer[2], buffer[3]};
      end
    end
  end

endmodule

// File: tb/tb_recepcao_medida_dht11.sv
// Bench for recepcao_medida_dht11: serial frames driven bit by bit, outputs
// compared each cycle against a transaction-level model of the request cycle.
module tb_recepcao_medida_dht11;

  localparam int CPB     = 4;
  localparam int TIMEOUT = 2000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        medir = 1'b0;
  logic        rx_serial = 1'b1;
  logic        medir_dht11_out, pronto, erro_timeout, erro_dados;
  logic [15:0] temperatura, umidade;
  logic [2:0]  db_estado;

  int checks = 0;
  int errors = 0;

  // Model state: request active, age since request edge, held results.
  bit          chk_en = 0;
  bit          m_req = 0;
  bit          m_prev_pulse = 0;
  int          m_age = 0;
  logic [15:0] m_temp = '0, m_umid = '0;
  logic [15:0] pend_temp = '0, pend_umid = '0;
  int          exp_kind = 0;
  int          pulse_count = 0;
  int          last_kind = 0;
  int          cyc = 0, req_cyc = 0, pulse_lat = 0;

  recepcao_medida_dht11 #(
    .CLKS_PER_BIT   (CPB),
    .TIMEOUT_CICLOS (TIMEOUT),
    .HEADER         (8'hAA)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .medir           (medir),
    .rx_serial       (rx_serial),
    .medir_dht11_out (medir_dht11_out),
    .pronto          (pronto),
    .erro_timeout    (erro_timeout),
    .erro_dados      (erro_dados),
    .temperatura     (temperatura),
    .umidade         (umidade),
    .db_estado       (db_estado)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the model (kinds: 1 pronto, 2 dados, 3 timeout).
  initial begin
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (chk_en && reset) begin
        int  kind_now;
        bit  exp_et;
        if (m_req) m_age++;
        else if (medir && !m_prev_pulse) begin
          m_req   = 1;
          m_age   = 0;
          req_cyc = cyc;
        end
        kind_now = pronto ? 1 : erro_dados ? 2 : erro_timeout ? 3 : 0;
        check_output("pulse_exclusive", 32'(int'(pronto) + int'(erro_dados) + int'(erro_timeout)) <= 1, 1);
        exp_et = m_req && (m_age == TIMEOUT);
        check_output("erro_timeout", erro_timeout, exp_et);
        if (pronto || erro_dados) begin
          check_output("pulse_kind_now", kind_now, exp_kind);
          check_output("pulse_while_requested", m_req, 1);
        end
        if (kind_now != 0) begin
          if (pronto && exp_kind == 1) begin
            m_temp = pend_temp;
            m_umid = pend_umid;
          end
          m_req     = 0;
          pulse_lat = cyc - req_cyc;
          last_kind = kind_now;
          pulse_count++;
          check_output("db_estado_pulse", db_estado, 32'(kind_now + 3));
        end else if (m_req) begin
          check_output("db_estado_busy", (db_estado >= 3'd1 && db_estado <= 3'd3), 1);
        end else begin
          check_output("db_estado_idle", db_estado, 0);
        end
        check_output("temperatura", temperatura, m_temp);
        check_output("umidade", umidade, m_umid);
        check_output("medir_dht11_out", medir_dht11_out, m_req);
        m_prev_pulse = (kind_now != 0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_medir();
    @(negedge clock);
    medir = 1'b1;
    @(negedge clock);
    medir = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    rx_serial = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      tick(CPB);
    end
    rx_serial = stop_ok;
    tick(CPB);
    rx_serial = 1'b1;
  endtask

  task automatic glitch();
    rx_serial = 1'b0;
    tick(1);
    rx_serial = 1'b1;
  endtask

  task automatic wait_pulse(input int pc0, input int kind, input int budget);
    int n = 0;
    while (pulse_count == pc0 && n < budget) begin
      @(posedge clock);
      #2;
      n++;
    end
    if (pulse_count == pc0) check_output("wait_pulse_expired", 0, 1);
    else                    check_output("pulse_kind", last_kind, kind);
  endtask

  task automatic apply_stimulus(input logic [7:0] th, input logic [7:0] tl,
                                input logic [7:0] uh, input logic [7:0] ul,
                                input logic [7:0] chk, input int kind,
                                input int strays, input bit medir_mid);
    int pc0;
    logic [7:0] s;
    exp_kind  = kind;
    pend_temp = {th, tl};
    pend_umid = {uh, ul};
    pc0 = pulse_count;
    pulse_medir();
    tick($urandom_range(0, 3));
    for (int i = 0; i < strays; i++) begin
      s = 8'($urandom);
      if (s == 8'hAA) s = 8'h55;
      send_byte(s, 1);
    end
    fork
      begin
        send_byte(8'hAA, 1);
        send_byte(th, 1);
        send_byte(tl, 1);
        send_byte(uh, 1);
        send_byte(ul, 1);
        send_byte(chk, 1);
      end
      begin
        if (medir_mid) begin
          tick($urandom_range(20, 150));
          pulse_medir();
        end
      end
    join
    wait_pulse(pc0, kind, 60);
    tick(3);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    m_req = 0; m_prev_pulse = 0; m_age = 0;
    m_temp = '0; m_umid = '0;
  endtask

  initial begin
    int pc0;
    logic [7:0] th, tl, uh, ul, chk;
    bit bad;

    tick(3);
    check_output("reset_temperatura", temperatura, 0);
    check_output("reset_umidade", umidade, 0);
    check_output("reset_db_estado", db_estado, 0);
    check_output("reset_pulses", {medir_dht11_out, pronto, erro_dados, erro_timeout}, 0);
    reset = 1'b1;
    tick(2);
    chk_en = 1;

    $display("[TB] valid frame 0019/003C");
    apply_stimulus(8'h00, 8'h19, 8'h00, 8'h3C, 8'h55, 1, 0, 0);
    check_output("t1_temperatura", temperatura, 16'h0019);
    check_output("t1_umidade", umidade, 16'h003C);
    check_output("t1_req_low", medir_dht11_out, 0);
    check_output("t1_db_estado", db_estado, 0);

    $display("[TB] bad checksum keeps previous values");
    apply_stimulus(8'h00, 8'h19, 8'h00, 8'h3C, 8'h56, 2, 0, 0);
    check_output("t2_temperatura", temperatura, 16'h0019);
    check_output("t2_umidade", umidade, 16'h003C);

    $display("[TB] stray bytes before header");
    exp_kind = 1; pend_temp = 16'h001E; pend_umid = 16'h0032;
    pc0 = pulse_count;
    pulse_medir();
    send_byte(8'h12, 1);
    send_byte(8'h34, 1);
    send_byte(8'hAA, 1); send_byte(8'h00, 1); send_byte(8'h1E, 1);
    send_byte(8'h00, 1); send_byte(8'h32, 1); send_byte(8'h50, 1);
    wait_pulse(pc0, 1, 60);
    check_output("t3_temperatura", temperatura, 16'h001E);
    check_output("t3_umidade", umidade, 16'h0032);
    tick(3);

    $display("[TB] silent bridge timeout");
    exp_kind = 3;
    pc0 = pulse_count;
    pulse_medir();
    wait_pulse(pc0, 3, TIMEOUT + 100);
    check_output("t4_timeout_latency", pulse_lat, TIMEOUT);
    check_output("t4_temperatura", temperatura, 16'h001E);
    tick(3);
    apply_stimulus(8'h01, 8'h02, 8'h03, 8'h04, 8'h0A, 1, 0, 0);
    check_output("t4_fresh_temperatura", temperatura, 16'h0102);

    $display("[TB] framing error in data byte");
    exp_kind = 2;
    pc0 = pulse_count;
    pulse_medir();
    send_byte(8'hAA, 1);
    send_byte(8'h00, 1);
    send_byte(8'h5A, 0);
    wait_pulse(pc0, 2, 60);
    check_output("t5_temperatura", temperatura, 16'h0102);
    tick(3);

    $display("[TB] idle-line glitch produces no byte");
    exp_kind = 1; pend_temp = 16'h0019; pend_umid = 16'h003C;
    pc0 = pulse_count;
    pulse_medir();
    tick(5); glitch(); tick(6);
    send_byte(8'hAA, 1); send_byte(8'h00, 1); send_byte(8'h19, 1);
    tick(5); glitch(); tick(6);
    send_byte(8'h00, 1); send_byte(8'h3C, 1); send_byte(8'h55, 1);
    wait_pulse(pc0, 1, 60);
    check_output("t6_umidade", umidade, 16'h003C);
    tick(3);

    $display("[TB] randomized frames");
    for (int k = 0; k < 8; k++) begin
      th = 8'($urandom); tl = 8'($urandom); uh = 8'($urandom); ul = 8'($urandom);
      chk = th + tl + uh + ul;
      bad = ($urandom_range(0, 3) == 0);
      if (bad) chk = chk + 8'($urandom_range(1, 255));
      apply_stimulus(th, tl, uh, ul, chk, bad ? 2 : 1,
                     $urandom_range(0, 2), ($urandom_range(0, 1) == 1));
      tick($urandom_range(0, 10));
    end

    $display("[TB] reset mid-frame");
    exp_kind = 1;
    pulse_medir();
    send_byte(8'hAA, 1); send_byte(8'h00, 1); send_byte(8'h19, 1);
    do_reset();
    #1;
    check_output("t7_rst_temperatura", temperatura, 0);
    check_output("t7_rst_umidade", umidade, 0);
    check_output("t7_rst_db_estado", db_estado, 0);
    check_output("t7_rst_req", medir_dht11_out, 0);
    tick(3);
    reset = 1'b1;
    tick(3);
    apply_stimulus(8'h00, 8'h17, 8'h00, 8'h41, 8'h58, 1, 0, 0);
    check_output("t7_temperatura", temperatura, 16'h0017);
    check_output("t7_umidade", umidade, 16'h0041);

    tick(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
